// File: rtl/pc_unit_if.sv
// Fetch-side bundle for pc_unit: redirect sources and fetch handshake in,
// presented thread/PC plus per-thread stall and PC state out.
interface pc_unit_if #(
    parameter int NUM_TRD = 8,
    parameter int PC_W    = 32
);
    localparam int TRD_W = $clog2(NUM_TRD);

    logic [NUM_TRD-1:0]      trd_en;
    logic                    jmp;
    logic [TRD_W-1:0]        jmp_trd;
    logic [PC_W-1:0]         jmp_pc;
    logic                    i_miss;
    logic [TRD_W-1:0]        i_miss_trd;
    logic [PC_W-1:0]         i_miss_pc;
    logic                    d_miss;
    logic [TRD_W-1:0]        d_miss_trd;
    logic [PC_W-1:0]         d_miss_pc;
    logic                    fill_done;
    logic [TRD_W-1:0]        fill_trd;
    logic                    fetch_rdy;
    logic                    fetch_vld;
    logic [TRD_W-1:0]        fetch_trd;
    logic [PC_W-1:0]         fetch_pc;
    logic [NUM_TRD-1:0]      trd_stall;
    logic [NUM_TRD*PC_W-1:0] pc_all;

    // Redirect sources and the fetch stage drive the request side
    modport master (
        output trd_en, jmp, jmp_trd, jmp_pc,
        output i_miss, i_miss_trd, i_miss_pc,
        output d_miss, d_miss_trd, d_miss_pc,
        output fill_done, fill_trd, fetch_rdy,
        input  fetch_vld, fetch_trd, fetch_pc, trd_stall, pc_all
    );

    // The PC unit itself
    modport slave (
        input  trd_en, jmp, jmp_trd, jmp_pc,
        input  i_miss, i_miss_trd, i_miss_pc,
        input  d_miss, d_miss_trd, d_miss_pc,
        input  fill_done, fill_trd, fetch_rdy,
        output fetch_vld, fetch_trd, fetch_pc, trd_stall, pc_all
    );
endinterface

// File: rtl/pc_unit.sv
// Per-thread PC register file with round-robin fetch arbitration for the
// barrel core. Redirects (d-miss > i-miss > jump > sequential) update each
// thread independently; misses park the thread until its fill returns.
module pc_unit #(
    parameter int              NUM_TRD  = 8,
    parameter int              PC_W     = 32,
    parameter int              PC_INC   = 1,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(32'h0000_1000)
) (
    input logic      clk,
    input logic      rst_n,
    pc_unit_if.slave bus
);
    localparam int              TRD_W = $clog2(NUM_TRD);
    localparam logic [PC_W-1:0] INC   = PC_W'(PC_INC);
    localparam logic [TRD_W-1:0] LAST = TRD_W'(NUM_TRD - 1);

    logic [PC_W-1:0]         pc_q [NUM_TRD];
    logic [PC_W-1:0]         pc_d [NUM_TRD];
    logic [NUM_TRD-1:0]      stall_q;
    logic [NUM_TRD-1:0]      stall_d;
    logic [NUM_TRD-1:0]      eligible;
    logic [TRD_W-1:0]        rr_ptr_q;
    logic [TRD_W-1:0]        rr_ptr_d;
    logic [TRD_W-1:0]        sel;
    logic                    found;
    logic                    accept;
    logic [NUM_TRD*PC_W-1:0] pc_all_w;

    assign eligible = bus.trd_en & ~stall_q;

    // Round-robin search starting at rr_ptr; falls back to thread 0 when idle
    always_comb begin
        logic [TRD_W-1:0] idx;
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_TRD; i++) begin
            idx = TRD_W'((int'(rr_ptr_q) + i) % NUM_TRD);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign accept = found & bus.fetch_rdy;

    // Pointer moves just past the accepted thread; a refused offer holds it
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (sel == LAST) ? '0 : sel + TRD_W'(1);
        end
    end

    // Per-thread next-state; ids outside 0..NUM_TRD-1 never match any slot
    for (genvar gi = 0; gi < NUM_TRD; gi++) begin : g_trd
        localparam logic [TRD_W-1:0] ID = TRD_W'(gi);
        logic d_hit;
        logic i_hit;
        logic j_hit;
        logic f_hit;
        logic inc_hit;

        assign d_hit   = bus.d_miss    && (bus.d_miss_trd == ID);
        assign i_hit   = bus.i_miss    && (bus.i_miss_trd == ID);
        assign j_hit   = bus.jmp       && (bus.jmp_trd    == ID);
        assign f_hit   = bus.fill_done && (bus.fill_trd   == ID);
        assign inc_hit = accept        && (sel            == ID);

        assign pc_d[gi] = d_hit   ? bus.d_miss_pc :
                          i_hit   ? bus.i_miss_pc :
                          j_hit   ? bus.jmp_pc    :
                          inc_hit ? pc_q[gi] + INC :
                                    pc_q[gi];

        // A new miss in the same cycle as a fill keeps the thread parked
        assign stall_d[gi] = d_hit | i_hit | (stall_q[gi] & ~f_hit);

        assign pc_all_w[gi*PC_W +: PC_W] = pc_q[gi];
    end

    // State registers: PCs, stall bits and arbitration pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TRD; i++) begin
                pc_q[i] <= RESET_PC;
            end
            stall_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            for (int i = 0; i < NUM_TRD; i++) begin
                pc_q[i] <= pc_d[i];
            end
            stall_q  <= stall_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.fetch_vld = found;
    assign bus.fetch_trd = sel;
    assign bus.fetch_pc  = pc_q[sel];
    assign bus.trd_stall = stall_q;
    assign bus.pc_all    = pc_all_w;
endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: stimulus pushes the expected fetch offer into a
// scoreboard each cycle, a monitor pops and compares on the falling edge.
module tb_pc_unit;
    localparam logic [31:0] R = 32'h0000_1000;

    typedef struct {
        bit          vld;
        logic [2:0]  trd;
        logic [31:0] pc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    pc_unit_if #(.NUM_TRD(8), .PC_W(32)) bus ();
    pc_unit_if #(.NUM_TRD(6), .PC_W(32)) bus6 ();

    pc_unit #(.NUM_TRD(8), .PC_W(32), .PC_INC(1), .RESET_PC(R)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    pc_unit #(.NUM_TRD(6), .PC_W(32), .PC_INC(1), .RESET_PC(R)) u_dut6 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus6)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    function automatic logic [31:0] pc8(int t);
        return bus.pc_all[t*32 +: 32];
    endfunction

    function automatic logic [31:0] pc6(int t);
        return bus6.pc_all[t*32 +: 32];
    endfunction

    task automatic push(bit v, int t, logic [31:0] pc);
        exp_t e;
        e.vld = v;
        e.trd = 3'(t);
        e.pc  = pc;
        sb.push_back(e);
    endtask

    task automatic clear_redirects();
        bus.jmp  = 0; bus.jmp_trd  = '0; bus.jmp_pc  = '0;
        bus.i_miss = 0; bus.i_miss_trd = '0; bus.i_miss_pc = '0;
        bus.d_miss = 0; bus.d_miss_trd = '0; bus.d_miss_pc = '0;
        bus.fill_done = 0; bus.fill_trd = '0;
        bus6.jmp  = 0; bus6.jmp_trd  = '0; bus6.jmp_pc  = '0;
        bus6.i_miss = 0; bus6.i_miss_trd = '0; bus6.i_miss_pc = '0;
        bus6.d_miss = 0; bus6.d_miss_trd = '0; bus6.d_miss_pc = '0;
        bus6.fill_done = 0; bus6.fill_trd = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_redirects();
    endtask

    // Monitor: one comparison per expected offer, sampled mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (bus.fetch_vld !== e.vld || bus.fetch_trd !== e.trd || bus.fetch_pc !== e.pc) begin
                    failures++;
                    $display("FAIL fetch actual vld=%0b trd=%0d pc=%h required vld=%0b trd=%0d pc=%h",
                             bus.fetch_vld, bus.fetch_trd, bus.fetch_pc, e.vld, e.trd, e.pc);
                end else begin
                    $display("ok   fetch vld=%0b trd=%0d pc=%h", e.vld, e.trd, e.pc);
                end
            end
        end
    end

    initial begin
        clear_redirects();
        bus.trd_en  = 8'h01;
        bus.fetch_rdy = 1'b1;
        bus6.trd_en = 6'h3F;
        bus6.fetch_rdy = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 32'(bus.trd_stall), 32'h0);
        chk("rst_pc3", pc8(3), R);
        rst_n = 1'b1;

        // single thread, sequential increments
        for (int k = 0; k < 4; k++) begin
            push(1, 0, R + 32'(k));
            tick();
        end
        chk("seq_pc0", pc8(0), R + 4);

        // round robin over 0,2,5,7
        bus.trd_en = 8'hA5;
        push(1, 2, R);     tick();
        push(1, 5, R);     tick();
        push(1, 7, R);     tick();
        push(1, 0, R + 4); tick();
        push(1, 2, R + 1); tick();

        // refused offers hold everything
        bus.fetch_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            push(1, 5, R + 1);
            tick();
        end
        chk("hold_pc5", pc8(5), R + 1);
        chk("hold_pc2", pc8(2), R + 2);
        chk("hold_pc0", pc8(0), R + 5);

        // redirect priority on one thread
        bus.fetch_rdy = 1'b1;
        bus.d_miss = 1; bus.d_miss_trd = 3; bus.d_miss_pc = 32'h100;
        bus.i_miss = 1; bus.i_miss_trd = 3; bus.i_miss_pc = 32'h200;
        bus.jmp    = 1; bus.jmp_trd    = 3; bus.jmp_pc    = 32'h300;
        push(1, 5, R + 1);
        tick();
        chk("prio_pc3", pc8(3), 32'h100);
        chk("prio_stall", 32'(bus.trd_stall), 32'h08);
        chk("prio_pc5", pc8(5), R + 2);

        // independent redirects to different threads
        bus.jmp    = 1; bus.jmp_trd    = 1; bus.jmp_pc    = 32'h40;
        bus.d_miss = 1; bus.d_miss_trd = 6; bus.d_miss_pc = 32'h600;
        push(1, 7, R + 1);
        tick();
        chk("jmp_pc1", pc8(1), 32'h40);
        chk("dm_pc6", pc8(6), 32'h600);
        chk("dm_stall", 32'(bus.trd_stall), 32'h48);
        chk("inc_pc7", pc8(7), R + 2);

        // stall thread 2, then set beats clear
        bus.i_miss = 1; bus.i_miss_trd = 2; bus.i_miss_pc = 32'h222;
        push(1, 0, R + 5);
        tick();
        chk("im_stall", 32'(bus.trd_stall), 32'h4C);
        chk("im_pc2", pc8(2), 32'h222);
        bus.fetch_rdy = 1'b0;
        bus.fill_done = 1; bus.fill_trd = 2;
        bus.d_miss = 1; bus.d_miss_trd = 2; bus.d_miss_pc = 32'h333;
        push(1, 5, R + 2);
        tick();
        chk("setwin_stall", 32'(bus.trd_stall), 32'h4C);
        chk("setwin_pc2", pc8(2), 32'h333);
        bus.fill_done = 1; bus.fill_trd = 2;
        push(1, 5, R + 2);
        tick();
        chk("fill_stall", 32'(bus.trd_stall), 32'h48);
        bus.fetch_rdy = 1'b1;
        push(1, 2, 32'h333);
        tick();
        chk("reenter_pc2", pc8(2), 32'h334);

        // miss on the thread being accepted overrides its increment
        bus.d_miss = 1; bus.d_miss_trd = 5; bus.d_miss_pc = 32'h555;
        push(1, 5, R + 2);
        tick();
        chk("accmiss_pc5", pc8(5), 32'h555);
        chk("accmiss_stall", 32'(bus.trd_stall), 32'h68);

        // PC wraps to zero
        bus.jmp = 1; bus.jmp_trd = 0; bus.jmp_pc = 32'hFFFF_FFFF;
        push(1, 7, R + 2);
        tick();
        chk("wrap_set", pc8(0), 32'hFFFF_FFFF);
        push(1, 0, 32'hFFFF_FFFF);
        tick();
        chk("wrap_pc0", pc8(0), 32'h0);

        // every enabled thread stalled
        bus.trd_en = 8'h68;
        push(0, 0, 32'h0);
        tick();
        chk("idle_pc0", pc8(0), 32'h0);

        // out-of-range thread ids on a 6-thread instance
        bus6.d_miss = 1; bus6.d_miss_trd = 1; bus6.d_miss_pc = 32'h66;
        tick();
        chk("n6_stall", 32'(bus6.trd_stall), 32'h02);
        bus6.fill_done = 1; bus6.fill_trd = 7;
        tick();
        chk("n6_fill7", 32'(bus6.trd_stall), 32'h02);
        bus6.d_miss = 1; bus6.d_miss_trd = 7; bus6.d_miss_pc = 32'h77;
        bus6.jmp    = 1; bus6.jmp_trd    = 6; bus6.jmp_pc    = 32'h99;
        tick();
        chk("n6_badid_stall", 32'(bus6.trd_stall), 32'h02);
        for (int t = 0; t < 6; t++) begin
            chk($sformatf("n6_pc%0d", t), pc6(t), (t == 1) ? 32'h66 : R);
        end

        // asynchronous reset mid-cycle
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_stall", 32'(bus.trd_stall), 32'h0);
        chk("arst_pc3", pc8(3), R);
        chk("arst_pc0", pc8(0), R);
        chk("arst_stall6", 32'(bus6.trd_stall), 32'h0);
        push(1, 3, R);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("sb_drain", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
